prog_loader: RTL and testbench

- Byte-stream program loader: the writer side of the program store that the CPF3 core fetches from.
- Receives a framed program image over an 8-bit valid/ready stream, typically from the UART receiver.
- Assembles big-endian 16-bit instruction words and writes them sequentially into the program RAM write port.
- Holds the core in reset (cpu_hold) until a complete, checksum-valid image has been written.

---
 rtl/prog_loader.sv | 120 ++++++++++++
 tb/tb_prog_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: takes a framed byte stream (length, big-endian words, checksum),
// writes words into program RAM and releases the core only after a valid image.
module prog_loader #(
  parameter int ADDR_W        = 8,
  parameter int MAX_WORDS     = 256,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  len_hi, hi_byte, chk;
  logic [15:0] len, n_rx, cnt_next;
  logic        accept, go;

  assign accept   = in_valid & in_ready;
  assign go       = start & (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign n_rx     = {len_hi, in_data};
  assign cnt_next = 16'(words_loaded) + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (go) state_nx = S_LEN_HI;
      S_LEN_HI: if (accept) state_nx = S_LEN_LO;
      S_LEN_LO:
        if (accept) begin
          if (n_rx > 16'(MAX_WORDS)) state_nx = S_ERR;
          else if (n_rx == 16'd0)    state_nx = S_CHK;
          else                       state_nx = S_DATA_HI;
        end
      S_DATA_HI: if (accept) state_nx = S_DATA_LO;
      S_DATA_LO: if (accept) state_nx = (cnt_next < len) ? S_DATA_HI : S_CHK;
      S_CHK:     if (accept) state_nx = (in_data == chk) ? S_DONE : S_ERR;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Status outputs are pure decodes of the state register, so in_ready
  // never depends combinationally on in_valid.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      S_IDLE:  cpu_hold = HOLD_AT_RESET;
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE:  begin done = 1'b1; cpu_hold = 1'b0; end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // words_loaded doubles as the write address counter; it is one bit wider
  // so a full MAX_WORDS image does not wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      len_hi       <= '0;
      len          <= '0;
      hi_byte      <= '0;
      chk          <= '0;
    end else begin
      mem_we <= 1'b0;
      if (go) begin
        words_loaded <= '0;
        chk          <= '0;
      end
      if (accept) begin
        case (state)
          S_LEN_HI:  len_hi <= in_data;
          S_LEN_LO:  len    <= n_rx;
          S_DATA_HI: begin
            hi_byte <= in_data;
            chk     <= chk + in_data;
          end
          S_DATA_LO: begin
            chk          <= chk + in_data;
            mem_we       <= 1'b1;
            mem_addr     <= words_loaded[ADDR_W-1:0];
            mem_wdata    <= {hi_byte, in_data};
            words_loaded <= words_loaded + (ADDR_W+1)'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames plus randomized frames checked against
// a frame-level model (expected writes, checksum verdict, word count).
module tb_prog_loader;
  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              rst, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, mem_we, cpu_hold, busy, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  logic [23:0] wlog[$];   // observed writes {addr, data}
  logic [15:0] img[$];    // image for the random frames

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) wlog.push_back({mem_addr, mem_wdata});

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Presents one byte and waits for the handshake edge; returns #1 after it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk); in_data = b; in_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      if (in_ready) begin @(posedge clk); got = 1'b1; end
      else @(negedge clk);
    end
    #1 in_valid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL handshake got timeout exp accept byte %h", b); end
  endtask

  // Sends header, img words (if n is legal) and the checksum, optionally corrupted.
  task automatic send_frame(input logic [15:0] n, input bit bad, input int maxgap);
    logic [7:0] sum;
    sum = 8'h00;
    send_byte(n[15:8], $urandom_range(0, maxgap));
    send_byte(n[7:0], $urandom_range(0, maxgap));
    if (n <= 16'(MAX_WORDS)) begin
      for (int i = 0; i < int'(n); i++) begin
        send_byte(img[i][15:8], $urandom_range(0, maxgap));
        send_byte(img[i][7:0], $urandom_range(0, maxgap));
        sum = sum + img[i][15:8] + img[i][7:0];
      end
      send_byte(bad ? sum + 8'h01 : sum, $urandom_range(0, maxgap));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, busy, done, error, cpu_hold} !== 6'b000001) begin
      errors++; $display("FAIL reset_status got %b exp 000001",
                         {in_ready, mem_we, busy, done, error, cpu_hold});
    end
    checks++;
    if ({mem_addr, mem_wdata, words_loaded} !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h/%0d exp 0/0/0", mem_addr, mem_wdata, words_loaded);
    end
  endtask

  task automatic test_basic();
    logic [7:0] f[7] = '{8'h00, 8'h02, 8'h17, 8'h02, 8'h00, 8'h7F, 8'h98};
    wlog.delete();
    pulse_start();
    checks++;
    if ({busy, cpu_hold, in_ready} !== 3'b111) begin
      errors++; $display("FAIL start_status got %b exp 111", {busy, cpu_hold, in_ready});
    end
    foreach (f[i]) send_byte(f[i], 0);
    repeat (2) @(negedge clk);
    checks++;
    if (wlog.size() != 2 || wlog[0] !== 24'h00_1702 || wlog[1] !== 24'h01_007F) begin
      errors++; $display("FAIL basic_writes got n=%0d %h %h exp 2 001702 01007f",
                         wlog.size(), wlog.size() > 0 ? wlog[0] : 24'h0, wlog.size() > 1 ? wlog[1] : 24'h0);
    end
    checks++;
    if ({busy, done, error, cpu_hold} !== 4'b0100 || words_loaded !== 9'd2) begin
      errors++; $display("FAIL basic_done got %b wl=%0d exp 0100 wl=2", {busy, done, error, cpu_hold}, words_loaded);
    end
  endtask

  task automatic test_bad_chk();
    logic [7:0] f[7] = '{8'h00, 8'h02, 8'h17, 8'h02, 8'h00, 8'h7F, 8'h99};
    wlog.delete();
    pulse_start();
    foreach (f[i]) send_byte(f[i], 1);
    repeat (2) @(negedge clk);
    checks++;
    if (wlog.size() != 2) begin errors++; $display("FAIL badchk_writes got %0d exp 2", wlog.size()); end
    checks++;
    if ({busy, done, error, cpu_hold} !== 4'b0011) begin
      errors++; $display("FAIL badchk_status got %b exp 0011", {busy, done, error, cpu_hold});
    end
  endtask

  task automatic test_zero();
    wlog.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (wlog.size() != 0 || done !== 1'b1 || words_loaded !== 9'd0) begin
      errors++; $display("FAIL zero_len got writes=%0d done=%b wl=%0d exp 0 1 0", wlog.size(), done, words_loaded);
    end
  endtask

  task automatic test_too_long();
    wlog.delete();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    @(negedge clk);
    checks++;
    if ({error, done, busy, in_ready, cpu_hold} !== 5'b10001 || wlog.size() != 0) begin
      errors++; $display("FAIL too_long got %b writes=%0d exp 10001 0",
                         {error, done, busy, in_ready, cpu_hold}, wlog.size());
    end
  endtask

  task automatic test_stream();
    wlog.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    pulse_start();   // must be ignored in DATA_HI
    checks++;
    if ({busy, in_ready, done, error} !== 4'b1100 || words_loaded !== 9'd0) begin
      errors++; $display("FAIL ignored_start got %b wl=%0d exp 1100 wl=0", {busy, in_ready, done, error}, words_loaded);
    end
    send_byte(8'hAB, 0);
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL early_we got %b exp 0", mem_we); end
    send_byte(8'hE0, 0);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h00, 16'hABE0}) begin
      errors++; $display("FAIL stream_write got %b %h %h exp 1 00 abe0", mem_we, mem_addr, mem_wdata);
    end
    send_byte(8'h8B, 0);
    checks++;
    if (mem_we !== 1'b0 || wlog.size() != 1) begin
      errors++; $display("FAIL we_width got we=%b writes=%0d exp 0 1", mem_we, wlog.size());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL stream_done got %b exp 1", done); end

    // Reset lands where the E0 byte would have been accepted.
    wlog.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'hAB, 0);
    @(negedge clk); in_data = 8'hE0; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wlog.size() != 0 || {in_ready, mem_we, busy, done, error, cpu_hold} !== 6'b000001) begin
      errors++; $display("FAIL rst_midload got writes=%0d status=%b exp 0 000001",
                         wlog.size(), {in_ready, mem_we, busy, done, error, cpu_hold});
    end
    checks++;
    if ({mem_addr, mem_wdata, words_loaded} !== '0) begin
      errors++; $display("FAIL rst_midload_data got %h/%h/%0d exp 0/0/0", mem_addr, mem_wdata, words_loaded);
    end
  endtask

  task automatic test_reload();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reload_pre got hold=%b exp 0", cpu_hold); end
    wlog.delete();
    pulse_start();
    checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL reload_hold got hold=%b done=%b exp 1 0", cpu_hold, done);
    end
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b0 || done !== 1'b1 || wlog.size() != 1 || wlog[0] !== 24'h00_0001) begin
      errors++; $display("FAIL reload_done got hold=%b done=%b writes=%0d exp 0 1 1 @0=0001",
                         cpu_hold, done, wlog.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [15:0] n;
      bit bad, ok_len, mism;
      int exp_n;
      if (it == 0)                          n = 16'(MAX_WORDS);
      else if ($urandom_range(0, 7) == 0)   n = 16'(MAX_WORDS + 1 + $urandom_range(0, 2000));
      else                                  n = 16'($urandom_range(0, 8));
      bad    = ($urandom_range(0, 3) == 0);
      ok_len = (n <= 16'(MAX_WORDS));
      exp_n  = ok_len ? int'(n) : 0;
      img.delete();
      for (int i = 0; i < exp_n; i++) img.push_back(16'($urandom));
      wlog.delete();
      pulse_start();
      send_frame(n, bad, (it == 0) ? 0 : 2);
      repeat (2) @(negedge clk);
      mism = (wlog.size() != exp_n);
      for (int i = 0; i < exp_n && !mism; i++)
        if (wlog[i] !== {8'(i), img[i]}) mism = 1'b1;
      checks++;
      if (mism) begin errors++; $display("FAIL rand_writes it=%0d n=%0d got %0d writes exp %0d", it, n, wlog.size(), exp_n); end
      checks++;
      if ({busy, done, error, cpu_hold} !== {1'b0, ok_len && !bad, !(ok_len && !bad), !(ok_len && !bad)}
          || words_loaded !== 9'(exp_n)) begin
        errors++; $display("FAIL rand_status it=%0d n=%0d bad=%0d got %b wl=%0d exp wl=%0d",
                           it, n, bad, {busy, done, error, cpu_hold}, words_loaded, exp_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_chk();
    test_zero();
    test_too_long();
    test_stream();
    test_reload();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
